// File: rtl/virtio_blk_dma.sv
// virtio_blk_dma: copies whole 512-byte sectors between guest memory and the disk image
// one word at a time, then writes the virtio status byte and pulses completion.
module virtio_blk_dma #(
  parameter int DISK_SECTORS = 2048
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_type,
  input  logic [63:0] cmd_sector,
  input  logic [31:0] cmd_buffer_addr,
  input  logic [31:0] cmd_len,
  input  logic [31:0] cmd_status_addr,
  output logic        done_valid,
  output logic [7:0]  done_status,
  output logic [31:0] done_len,
  output logic        mem_request_enable,
  output logic        mem_mode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_response_enable,
  input  logic [31:0] mem_data,
  output logic        disk_request_enable,
  output logic        disk_mode,
  output logic [31:0] disk_addr,
  output logic [31:0] disk_wdata,
  input  logic        disk_response_enable,
  input  logic [31:0] disk_data
);
  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef enum logic [3:0] {
    IDLE, CHECK, RD_SRC, WAIT_SRC, WR_DST, WAIT_DST, STATUS, WAIT_STATUS, DONE
  } state_t;

  state_t      state, state_n;
  logic [31:0] c_type, c_buf, c_len, c_stat, idx, idx_n;
  logic [63:0] c_sector;
  logic [7:0]  status, status_n, status_cur;
  logic [32:0] end_sector;
  logic [31:0] mem_a, disk_a, src_data;
  logic        is_out, src_rsp, dst_rsp, last, rd_n, xfer_n, mem_side;

  assign cmd_ready  = state == IDLE;
  assign is_out     = c_type[0];
  assign end_sector = {1'b0, c_sector[31:0]} + {10'd0, c_len[31:9]};
  assign status_n   = c_type > 32'd1 ? 8'd2 :
                      (c_len == 32'd0 || c_len[8:0] != 9'd0 || c_buf[1:0] != 2'd0 ||
                       c_sector[63:32] != 32'd0 || end_sector > 33'(DISK_SECTORS)) ? 8'd1 : 8'd0;
  assign status_cur = state == CHECK ? status_n : status;
  assign src_rsp    = is_out ? mem_response_enable : disk_response_enable;
  assign dst_rsp    = is_out ? disk_response_enable : mem_response_enable;
  assign src_data   = is_out ? mem_data : disk_data;
  assign last       = idx + 32'd1 == {2'b00, c_len[31:2]};
  assign idx_n      = state == CHECK ? 32'd0 : (state == WAIT_DST && dst_rsp) ? idx + 32'd1 : idx;
  // Addresses follow the index the next request will carry, since idx advances on the same edge
  assign mem_a      = c_buf + {idx_n[29:0], 2'b00};
  assign disk_a     = {c_sector[22:0], 9'd0} + {idx_n[29:0], 2'b00};
  assign rd_n       = state_n == RD_SRC;
  assign xfer_n     = rd_n || state_n == WR_DST;
  assign mem_side   = is_out == rd_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:        state_n = cmd_valid ? CHECK : IDLE;
      CHECK:       state_n = status_n != 8'd0 ? STATUS : RD_SRC;
      RD_SRC:      state_n = WAIT_SRC;
      WAIT_SRC:    state_n = src_rsp ? WR_DST : WAIT_SRC;
      WR_DST:      state_n = WAIT_DST;
      WAIT_DST:    state_n = dst_rsp ? (last ? STATUS : RD_SRC) : WAIT_DST;
      STATUS:      state_n = WAIT_STATUS;
      WAIT_STATUS: state_n = mem_response_enable ? DONE : WAIT_STATUS;
      DONE:        state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state               <= IDLE;
      idx                 <= '0;
      status              <= '0;
      done_valid          <= 1'b0;
      done_status         <= '0;
      done_len            <= '0;
      mem_request_enable  <= 1'b0;
      mem_mode            <= MEMREQ_READ;
      mem_addr            <= '0;
      mem_wdata           <= '0;
      mem_wstrb           <= '0;
      disk_request_enable <= 1'b0;
      disk_mode           <= MEMREQ_READ;
      disk_addr           <= '0;
      disk_wdata          <= '0;
    end else begin
      state               <= state_n;
      idx                 <= idx_n;
      mem_request_enable  <= 1'b0;
      disk_request_enable <= 1'b0;
      done_valid          <= 1'b0;
      if (cmd_valid && cmd_ready) begin
        c_type   <= cmd_type;
        c_sector <= cmd_sector;
        c_buf    <= cmd_buffer_addr;
        c_len    <= cmd_len;
        c_stat   <= cmd_status_addr;
      end
      if (state == CHECK) status <= status_n;
      if (xfer_n && mem_side) begin
        mem_request_enable <= 1'b1;
        mem_mode           <= rd_n ? MEMREQ_READ : MEMREQ_WRITE;
        mem_addr           <= mem_a;
        mem_wdata          <= src_data;
        mem_wstrb          <= 4'b1111;
      end
      if (xfer_n && !mem_side) begin
        disk_request_enable <= 1'b1;
        disk_mode           <= rd_n ? MEMREQ_READ : MEMREQ_WRITE;
        disk_addr           <= disk_a;
        disk_wdata          <= src_data;
      end
      if (state_n == STATUS) begin
        mem_request_enable <= 1'b1;
        mem_mode           <= MEMREQ_WRITE;
        mem_addr           <= {c_stat[31:2], 2'b00};
        mem_wdata          <= {4{status_cur}};
        mem_wstrb          <= 4'b0001 << c_stat[1:0];
      end
      if (state_n == DONE) begin
        done_valid  <= 1'b1;
        done_status <= status;
        done_len    <= (status == 8'd0 && !is_out) ? c_len : 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_virtio_blk_dma.sv
// tb_virtio_blk_dma: directed checks of sector copies, error paths, timing and reset abort.
module tb_virtio_blk_dma;
  logic        clk = 1'b0, rstn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_type, cmd_buffer_addr, cmd_len, cmd_status_addr;
  logic [63:0] cmd_sector;
  logic        done_valid;
  logic [7:0]  done_status;
  logic [31:0] done_len;
  logic        mem_request_enable, mem_mode, mem_response_enable;
  logic [31:0] mem_addr, mem_wdata, mem_data;
  logic [3:0]  mem_wstrb;
  logic        disk_request_enable, disk_mode, disk_response_enable;
  logic [31:0] disk_addr, disk_wdata, disk_data;

  virtio_blk_dma #(.DISK_SECTORS(2048)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_sector(cmd_sector), .cmd_buffer_addr(cmd_buffer_addr),
    .cmd_len(cmd_len), .cmd_status_addr(cmd_status_addr),
    .done_valid(done_valid), .done_status(done_status), .done_len(done_len),
    .mem_request_enable(mem_request_enable), .mem_mode(mem_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_response_enable(mem_response_enable), .mem_data(mem_data),
    .disk_request_enable(disk_request_enable), .disk_mode(disk_mode), .disk_addr(disk_addr),
    .disk_wdata(disk_wdata), .disk_response_enable(disk_response_enable), .disk_data(disk_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          cyc;
  } req_t;

  req_t        mlog[$], dlog[$];
  logic [31:0] disk [0:262143];
  logic [31:0] gmem [logic [31:0]];
  logic [31:0] g, m_rdata = '0, d_rdata = '0;
  logic        m_pend = 1'b0, d_pend = 1'b0, m_stray = 1'b0, d_stray = 1'b0, stray_en = 1'b0;
  int          m_cnt = 0, d_cnt = 0, max_dly = 0;
  int          cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0, dc0 = 0;
  logic [7:0]  got_st;
  logic [31:0] got_len;
  int          checks = 0, errors = 0;

  function automatic logic [31:0] dpat(int k);
    return k * 32'h9E3779B1 ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] gpat(logic [31:0] a);
    return a ^ 32'hC3C3_3C3C;
  endfunction

  function automatic logic [31:0] grd(logic [31:0] a);
    return gmem.exists(a) ? gmem[a] : gpat(a);
  endfunction

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  assign mem_response_enable  = (m_pend && m_cnt == 0) || m_stray;
  assign mem_data             = m_stray ? 32'hDEAD_BEEF : m_rdata;
  assign disk_response_enable = (d_pend && d_cnt == 0) || d_stray;
  assign disk_data            = d_stray ? 32'hBAD0_BAD0 : d_rdata;

  // Responders and monitor share one block so the cycle stamp is consistent across logs
  always @(posedge clk) begin
    cyc++;
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (done_valid) begin
      done_cnt++;
      done_cyc = cyc;
      got_st   = done_status;
      got_len  = done_len;
    end
    m_stray <= 1'b0;
    d_stray <= 1'b0;
    if (mem_request_enable) begin
      mlog.push_back('{mem_mode, mem_addr, mem_wdata, mem_wstrb, cyc});
      if (mem_mode) begin
        g = grd(mem_addr);
        for (int b = 0; b < 4; b++) if (mem_wstrb[b]) g[8*b +: 8] = mem_wdata[8*b +: 8];
        gmem[mem_addr] = g;
      end else m_rdata <= grd(mem_addr);
      m_pend <= 1'b1;
      m_cnt  <= $urandom_range(max_dly, 0);
    end else if (m_pend) begin
      if (m_cnt == 0) m_pend <= 1'b0;
      else m_cnt <= m_cnt - 1;
    end else if (stray_en && d_pend && $urandom_range(2, 0) == 0) m_stray <= 1'b1;
    if (disk_request_enable) begin
      dlog.push_back('{disk_mode, disk_addr, disk_wdata, 4'hF, cyc});
      if (disk_mode) disk[disk_addr[19:2]] = disk_wdata;
      else d_rdata <= disk[disk_addr[19:2]];
      d_pend <= 1'b1;
      d_cnt  <= $urandom_range(max_dly, 0);
    end else if (d_pend) begin
      if (d_cnt == 0) d_pend <= 1'b0;
      else d_cnt <= d_cnt - 1;
    end else if (stray_en && m_pend && $urandom_range(2, 0) == 0) d_stray <= 1'b1;
  end

  task automatic send(logic [31:0] t, logic [63:0] s, logic [31:0] ba, logic [31:0] l, logic [31:0] st);
    mlog.delete();
    dlog.delete();
    dc0 = done_cnt;
    @(negedge clk);
    cmd_type = t;
    cmd_sector = s;
    cmd_buffer_addr = ba;
    cmd_len = l;
    cmd_status_addr = st;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (done_cnt == dc0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", done_cnt != dc0, 1);
  endtask

  task automatic check_status_wr(string tag, logic [31:0] st, logic [7:0] code);
    if (mlog.size() > 0)
      check(tag, {mlog[$].w, mlog[$].a, mlog[$].s, mlog[$].d},
            {1'b1, st & ~32'h3, 4'b0001 << st[1:0], {4{code}}});
    else check(tag, 0, 1);
  endtask

  task automatic verify_in(int sec, logic [31:0] ba, int n, logic [31:0] st);
    int bad = 0;
    check("in_disk_reads", dlog.size(), n);
    check("in_mem_writes", mlog.size(), n + 1);
    foreach (dlog[i]) if (dlog[i].w || dlog[i].a != sec * 512 + 4 * i) bad++;
    for (int i = 0; i < n && i < mlog.size(); i++)
      if (!mlog[i].w || mlog[i].a != ba + 4 * i || mlog[i].d != dpat(sec * 128 + i) || mlog[i].s != 4'hF) bad++;
    check("in_data", bad, 0);
    check("in_guest_word", grd(ba + 4 * (n - 1)), dpat(sec * 128 + n - 1));
    check_status_wr("in_status_wr", st, 8'd0);
  endtask

  task automatic verify_out(int sec, logic [31:0] ba, int n, logic [31:0] st);
    int bad = 0;
    check("out_mem_reqs", mlog.size(), n + 1);
    check("out_disk_writes", dlog.size(), n);
    foreach (dlog[i]) if (!dlog[i].w || dlog[i].a != sec * 512 + 4 * i || dlog[i].d != gpat(ba + 4 * i)) bad++;
    for (int i = 0; i < n && i < mlog.size(); i++) if (mlog[i].w || mlog[i].a != ba + 4 * i) bad++;
    check("out_data", bad, 0);
    check("out_disk_word", disk[sec * 128 + n - 1], gpat(ba + 4 * (n - 1)));
    check_status_wr("out_status_wr", st, 8'd0);
  endtask

  logic [31:0] e_t [7] = '{32'd4, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd7};
  logic [63:0] e_s [7] = '{64'd0, 64'd0, 64'd2047, 64'd0, 64'd0, 64'h1_0000_0003, 64'd0};
  logic [31:0] e_l [7] = '{32'd512, 32'd500, 32'd1024, 32'd0, 32'd512, 32'd512, 32'd500};
  logic [31:0] e_b [7] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h102, 32'h100, 32'h100};
  logic [7:0]  e_x [7] = '{8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};

  initial begin
    logic [31:0] st;
    int n;
    for (int k = 0; k < 262144; k++) disk[k] = dpat(k);
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_type = '0;
    cmd_sector = '0;
    cmd_buffer_addr = '0;
    cmd_len = '0;
    cmd_status_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", {done_valid, done_status, done_len}, 0);
    check("rst_mem", {mem_request_enable, mem_mode, mem_addr, mem_wdata, mem_wstrb}, 0);
    check("rst_disk", {disk_request_enable, disk_mode, disk_addr, disk_wdata}, 0);
    rstn = 1'b1;
    @(negedge clk);

    send(32'd0, 64'd3, 32'h8000_1000, 32'd512, 32'h8000_2002);
    wait_done(1000);
    check("in_done_cycle", done_cyc - acc_cyc, 516);
    check("in_first_req", dlog.size() > 0 ? dlog[0].cyc - acc_cyc : -1, 2);
    check("in_status_req", mlog.size() > 0 ? mlog[$].cyc - acc_cyc : -1, 514);
    check("in_done", {got_st, got_len}, {8'd0, 32'd512});
    check("in_ready_after", cmd_ready, 1);
    verify_in(3, 32'h8000_1000, 128, 32'h8000_2002);

    send(32'd1, 64'd0, 32'h9000_0000, 32'd1024, 32'h9000_1000);
    wait_done(2000);
    check("out_done", {got_st, got_len}, {8'd0, 32'd0});
    check("out_done_cycle", done_cyc - acc_cyc, 4 + 4 * 256);
    verify_out(0, 32'h9000_0000, 256, 32'h9000_1000);

    for (int i = 0; i < 7; i++) begin
      st = 32'hA000_0000 + i;
      send(e_t[i], e_s[i], e_b[i], e_l[i], st);
      wait_done(50);
      check($sformatf("err%0d_done", i), {got_st, got_len}, {e_x[i], 32'd0});
      check($sformatf("err%0d_cycle", i), done_cyc - acc_cyc, 4);
      check($sformatf("err%0d_traffic", i), {dlog.size(), mlog.size()}, {32'd0, 32'd1});
      check($sformatf("err%0d_status_req", i), mlog.size() > 0 ? mlog[0].cyc - acc_cyc : -1, 2);
      check_status_wr($sformatf("err%0d_status_wr", i), st, e_x[i]);
    end

    send(32'd1, 64'd2047, 32'h8800_6000, 32'd512, 32'h8800_7000);
    wait_done(1000);
    check("last_sector_done", {got_st, got_len}, {8'd0, 32'd0});
    verify_out(2047, 32'h8800_6000, 128, 32'h8800_7000);

    max_dly = 5;
    stray_en = 1'b1;
    send(32'd0, 64'd10, 32'h8000_4000, 32'd1024, 32'h8000_5001);
    wait_done(6000);
    check("rnd_in_done", {got_st, got_len}, {8'd0, 32'd1024});
    verify_in(10, 32'h8000_4000, 256, 32'h8000_5001);
    send(32'd1, 64'd20, 32'h8800_0000, 32'd512, 32'h8800_1003);
    wait_done(3000);
    check("rnd_out_done", {got_st, got_len}, {8'd0, 32'd0});
    verify_out(20, 32'h8800_0000, 128, 32'h8800_1003);
    max_dly = 0;
    stray_en = 1'b0;
    repeat (10) @(negedge clk);

    send(32'd0, 64'd5, 32'h8000_8000, 32'd512, 32'h8000_9000);
    n = 0;
    while (dlog.size() < 61 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_word60", dlog.size(), 61);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_strobes", {mem_request_enable, disk_request_enable}, 0);
    check("abort_ready", cmd_ready, 1);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt, dc0);
    check("abort_mem_writes", mlog.size(), 60);
    n = 0;
    foreach (mlog[i]) if (mlog[i].a == 32'h8000_9000) n++;
    check("abort_no_status", n, 0);

    send(32'd1, 64'd1, 32'h8800_2000, 32'd512, 32'h8800_3000);
    wait_done(1000);
    check("post_abort_done", {got_st, got_len}, {8'd0, 32'd0});
    verify_out(1, 32'h8800_2000, 128, 32'h8800_3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/virtio_blk_dma.md
# virtio_blk_dma

Sector transfer engine downstream of the virtio block controller: accepts one decoded block request (type, sector, guest buffer, length, status byte address), copies whole 512-byte sectors between guest memory and the disk image port one 32-bit word at a time, writes the virtio status byte, and reports completion. It is the `CONTROL_DISK` stage: the controller hands off after parsing the three descriptors and resumes on `done_valid`.

## Interface
- `DISK_SECTORS`, default 2048: disk image capacity in 512-byte sectors.
- `clk`  in  1  clock; everything on rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  request present.
- `cmd_ready`  out  1  high only in IDLE; accept = `cmd_valid && cmd_ready`.
- `cmd_type`  in  32  virtio btype: 0 = IN (disk→guest), 1 = OUT (guest→disk), other = unsupported.
- `cmd_sector`  in  64  first sector.
- `cmd_buffer_addr`  in  32  guest buffer byte address.
- `cmd_len`  in  32  buffer length, bytes.
- `cmd_status_addr`  in  32  guest byte address of status byte.
- `done_valid`  out  1  one-cycle completion pulse.
- `done_status`  out  8  0 OK, 1 IOERR, 2 UNSUPP; valid with `done_valid`.
- `done_len`  out  32  bytes written to guest buffer (`cmd_len` for OK IN, else 0).
- `mem_request_enable`, `mem_mode`, `mem_addr[31:0]`, `mem_wdata[31:0]`, `mem_wstrb[3:0]`  out  guest memory request; `mem_mode` uses `MEMREQ_READ`/`MEMREQ_WRITE` from `def.sv`.
- `mem_response_enable`  in  1, `mem_data`  in  32  guest memory response.
- `disk_request_enable`, `disk_mode`, `disk_addr[31:0]`, `disk_wdata[31:0]`  out  disk image request (byte address, full-word writes).
- `disk_response_enable`  in  1, `disk_data`  in  32  disk response.

## Operation
- Bus protocol (both ports): request strobe high exactly one cycle with mode/addr/data; wait for response strobe (≥1 cycle later); one outstanding request per port; never both ports in flight. Responses outside a WAIT state are ignored.
- States: IDLE → CHECK → {RD_SRC → WAIT_SRC → WR_DST → WAIT_DST}×N → STATUS → WAIT_STATUS → DONE → IDLE.
- IDLE: latch all `cmd_*` on accept.
- CHECK priority: type∉{0,1} → UNSUPP; `len==0`, `len[8:0]!=0`, `buffer_addr[1:0]!=0`, `sector[63:32]!=0`, or `sector + len/512 > DISK_SECTORS` (33-bit compare, no wrap) → IOERR; error → STATUS directly, no data traffic. Else N = len/4 words, word index i = 0.
- Source/destination: IN reads disk at `sector*512 + 4i`, writes guest at `buffer_addr + 4i` with wstrb 4'b1111; OUT reads guest, writes disk.
- Read data latched in WAIT_SRC on response; written in WR_DST. After WAIT_DST response: i+1; i==N → STATUS.
- STATUS: mem write, `mem_addr = {status_addr[31:2],2'b00}`, `mem_wstrb = 4'b0001 << status_addr[1:0]`, `mem_wdata = {4{status}}`.
- DONE: `done_valid`=1 with status/len for one cycle.
- Address arithmetic 32-bit, wraps modulo 2^32 silently (range check guards disk side only).
- Reset (any state, incl. mid-transfer): return to IDLE, abort, no status write, no `done_valid`.

## Timing
- Reset values: `cmd_ready`=1 (after first clock with rstn low, then rstn high), `done_valid`=0, `done_status`=0, `done_len`=0, all request strobes 0, `mem_mode`/`disk_mode`=read, all addr/wdata/wstrb=0.
- Request outputs registered; strobe in RD_SRC/WR_DST/STATUS cycle only.
- With single-cycle-latency responders, accept at cycle T: first request T+2; 4 cycles/word; status request T+2+4N; `done_valid` T+4+4N; `cmd_ready` high again T+5+4N. One sector (N=128): `done_valid` at T+516.
- Error path: status request T+2, `done_valid` T+4.
- Longer latency stretches only WAIT states; no timeout.
- `cmd_valid` ignored while `cmd_ready`=0; back-to-back command accepted in the IDLE cycle after DONE.

## Test plan
- IN, sector 3, len 512, buffer 0x8000_1000, status 0x8000_2002, 1-cycle memories → 128 disk reads 0x600..0x7FC, 128 guest writes 0x8000_1000..0x8000_11FC matching data, status write addr 0x8000_2000 wstrb 4'b0100 data 0x00000000, `done_valid` at T+516, done_len 512.
- OUT, sector 0, len 1024 → guest reads, disk writes 0x000..0x3FC identical data, done_status 0, done_len 0.
- cmd_type 4 → no data traffic, status byte 2, `done_valid` at T+4; len 500 → status 1; sector 2047 len 1024 (DISK_SECTORS 2048) → status 1.
- Random 0–5-cycle response delays on both ports, stray response strobes in non-WAIT states → data identical, exactly one request per word per port.
- rstn low mid-word 60 of a transfer → next cycle all strobes 0, `cmd_ready` 1, no status write, no `done_valid`; subsequent command completes normally.
